// File: rtl/axi_rd_responder.sv
// AXI4 read responder serving single-outstanding bursts from a 64-bit word memory with a side load port.
// Optional per-beat address range checking is enabled by defining AXI_RD_RANGE_CHECK_EN.
module axi_rd_responder #(
    parameter int unsigned             ID_WIDTH   = 13,
    parameter int unsigned             ADDR_WIDTH = 64,
    parameter int unsigned             DATA_WIDTH = 64,
    parameter int unsigned             MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = {ADDR_WIDTH{1'b0}},
    parameter int unsigned             RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data
);
    localparam int unsigned           IDX_W    = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]            LAT_LAST = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    unsup_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              beat_q;
    logic [3:0]              lat_q;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]     rid_q, rid_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

    logic                    ar_hs_s, beat_hs_s, lat_done_s, ar_unsup_s;
    logic [ADDR_WIDTH-1:0]   next_addr_s;
    logic                    pres_en_s, pres_unsup_s, pres_err_s;
    logic [ADDR_WIDTH-1:0]   pres_addr_s, off_s;
    logic [7:0]              pres_beat_s, pres_len_s;
    logic [ID_WIDTH-1:0]     pres_id_s;
    logic [IDX_W-1:0]        idx_s;

    function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] bytes, mask, incr, nxt;
        bytes = ONE_A << size;
        mask  = (({{(ADDR_WIDTH-8){1'b0}}, len} + ONE_A) << size) - ONE_A;
        incr  = addr + bytes;
        case (burst)
            2'd0:    nxt = addr;
            2'd1:    nxt = incr;
            2'd2:    nxt = (addr & ~mask) | (incr & mask);
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    function automatic logic burst_unsupported(
        input logic [2:0] addr_lsb,
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic [2:0] lane_mask;
        logic       bad;
        lane_mask = 3'((4'd1 << size[1:0]) - 4'd1);
        bad       = (burst == 2'd3) || (size > 3'd3);
        if (burst == 2'd2) begin
            if (!((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))) begin
                bad = 1'b1;
            end
            if ((addr_lsb & lane_mask) != 3'd0) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign ar_hs_s     = s_axi_arvalid && arready_q;
    assign beat_hs_s   = rvalid_q && s_axi_rready;
    assign lat_done_s  = (lat_q == LAT_LAST);
    assign ar_unsup_s  = burst_unsupported(s_axi_araddr[2:0], s_axi_arlen, s_axi_arsize, s_axi_arburst);
    assign next_addr_s = next_beat_addr(addr_q, size_q, len_q, burst_q);

    // Backing memory: load port only, contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    state_d = (RD_LATENCY == 1) ? ST_BEAT : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_done_s) begin
                    state_d = ST_BEAT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_BEAT: begin
                if (beat_hs_s && rlast_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BEAT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select which beat (if any) is launched into the output registers this cycle.
    always_comb begin
        pres_en_s    = 1'b0;
        pres_addr_s  = addr_q;
        pres_beat_s  = beat_q;
        pres_len_s   = len_q;
        pres_id_s    = id_q;
        pres_unsup_s = unsup_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs_s && (RD_LATENCY == 1)) begin
                    pres_en_s    = 1'b1;
                    pres_addr_s  = s_axi_araddr;
                    pres_beat_s  = 8'd0;
                    pres_len_s   = s_axi_arlen;
                    pres_id_s    = s_axi_arid;
                    pres_unsup_s = ar_unsup_s;
                end else begin
                    pres_en_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (lat_done_s) begin
                    pres_en_s   = 1'b1;
                    pres_beat_s = 8'd0;
                end else begin
                    pres_en_s = 1'b0;
                end
            end
            ST_BEAT: begin
                if (beat_hs_s && !rlast_q) begin
                    pres_en_s   = 1'b1;
                    pres_addr_s = next_addr_s;
                    pres_beat_s = beat_q + 8'd1;
                end else begin
                    pres_en_s = 1'b0;
                end
            end
            default: pres_en_s = 1'b0;
        endcase
    end

    assign off_s = pres_addr_s - BASE_ADDR;
    assign idx_s = IDX_W'(off_s >> 3);

`ifdef AXI_RD_RANGE_CHECK_EN
    assign pres_err_s = pres_unsup_s || (pres_addr_s < BASE_ADDR) ||
                        ((off_s >> (IDX_W + 3)) != {ADDR_WIDTH{1'b0}});
`else
    assign pres_err_s = pres_unsup_s;
`endif

    // FSM outputs: next values of the registered R channel and arready.
    always_comb begin
        arready_d = (state_d == ST_IDLE);
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        if (pres_en_s) begin
            rvalid_d = 1'b1;
            rdata_d  = pres_err_s ? {DATA_WIDTH{1'b0}} : mem_q[idx_s];
            rresp_d  = pres_err_s ? 2'b10 : 2'b00;
            rlast_d  = (pres_beat_s == pres_len_s);
            rid_d    = pres_id_s;
        end else if (beat_hs_s) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rid_q     <= {ID_WIDTH{1'b0}};
        end else begin
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
        end
    end

    // Latched request, current beat address and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q    <= {ID_WIDTH{1'b0}};
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            unsup_q <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            beat_q  <= 8'd0;
            lat_q   <= 4'd0;
        end else if (ar_hs_s) begin
            id_q    <= s_axi_arid;
            len_q   <= s_axi_arlen;
            size_q  <= s_axi_arsize;
            burst_q <= s_axi_arburst;
            unsup_q <= ar_unsup_s;
            addr_q  <= s_axi_araddr;
            beat_q  <= 8'd0;
            lat_q   <= 4'd0;
        end else if (pres_en_s) begin
            addr_q  <= pres_addr_s;
            beat_q  <= pres_beat_s;
        end else if (state_q == ST_WAIT) begin
            lat_q   <= lat_q + 4'd1;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=4.
module tb_axi_rd_responder;

    typedef struct packed {
        logic [12:0]      id;
        logic [63:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [7:0][15:0] idx;
        logic [7:0]       err;
    } vec_t;

`ifdef AXI_RD_RANGE_CHECK_EN
    localparam logic [7:0] ERR_CROSS = 8'b0000_1100;
    localparam logic [7:0] ERR_TOP   = 8'b0000_0001;
`else
    localparam logic [7:0] ERR_CROSS = 8'b0000_0000;
    localparam logic [7:0] ERR_TOP   = 8'b0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] arid = 13'd0;
    logic [63:0] araddr = 64'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd0;
    logic [1:0]  arburst = 2'd0;
    logic        arvalid [2];
    logic        rready = 1'b0;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = 12'd0;
    logic [63:0] ld_data = 64'd0;

    logic        arready_w [2];
    logic [12:0] rid_w     [2];
    logic [63:0] rdata_w   [2];
    logic [1:0]  rresp_w   [2];
    logic        rlast_w   [2];
    logic        rvalid_w  [2];

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [12];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_rd_responder #(.RD_LATENCY((g == 0) ? 1 : 4)) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .s_axi_arid    (arid),
            .s_axi_araddr  (araddr),
            .s_axi_arlen   (arlen),
            .s_axi_arsize  (arsize),
            .s_axi_arburst (arburst),
            .s_axi_arvalid (arvalid[g]),
            .s_axi_arready (arready_w[g]),
            .s_axi_rid     (rid_w[g]),
            .s_axi_rdata   (rdata_w[g]),
            .s_axi_rresp   (rresp_w[g]),
            .s_axi_rlast   (rlast_w[g]),
            .s_axi_rvalid  (rvalid_w[g]),
            .s_axi_rready  (rready),
            .ld_en         (ld_en),
            .ld_addr       (ld_addr),
            .ld_data       (ld_data)
        );
    end

    function automatic logic [63:0] img(input logic [15:0] i);
        return {16'hA5A5, 32'h0000_0000, i};
    endfunction

    function automatic logic [7:0][15:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        logic [7:0][15:0] r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
        return r;
    endfunction

    function automatic vec_t mkv(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input logic [7:0][15:0] idx, input logic [7:0] err);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.idx = idx; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request on instance d and check every beat; pat gives rready per cycle.
    task automatic run_burst(input int d, input vec_t v, input logic [15:0] pat, input int lat);
        int  b;
        int  k;
        logic seen;
        logic [63:0] exp_data;
        @(negedge clk);
        check("arready_idle", {63'd0, arready_w[d]}, 64'd1);
        arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
        arvalid[d] = 1'b1;
        @(posedge clk);
        #1 arvalid[d] = 1'b0;
        b = 0; k = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 64 && b <= int'(v.len); cyc++) begin
            @(negedge clk);
            k++;
            if (!seen && rvalid_w[d]) begin
                seen = 1'b1;
                check("latency", 64'(k), 64'(lat));
            end
            rready = pat[cyc % 16];
            if (rvalid_w[d]) begin
                exp_data = v.err[b] ? 64'd0 : img(v.idx[b]);
                check("rdata", rdata_w[d], exp_data);
                check("rresp", {62'd0, rresp_w[d]}, v.err[b] ? 64'd2 : 64'd0);
                check("rlast", {63'd0, rlast_w[d]}, (b == int'(v.len)) ? 64'd1 : 64'd0);
                check("rid", {51'd0, rid_w[d]}, {51'd0, v.id});
                check("arready_busy", {63'd0, arready_w[d]}, 64'd0);
                if (rready) b++;
            end else if (seen) begin
                check("rvalid_hold", {63'd0, rvalid_w[d]}, 64'd1);
            end
        end
        check("beats", 64'(b), 64'(v.len) + 64'd1);
        @(negedge clk);
        check("arready_after", {63'd0, arready_w[d]}, 64'd1);
        check("rvalid_after", {63'd0, rvalid_w[d]}, 64'd0);
    endtask

    initial begin
        int b;
        arvalid[0] = 1'b0;
        arvalid[1] = 1'b0;

        vecs[0]  = mkv(13'h0000, 64'h18, 8'd7, 3'd3, 2'd2, pk8(3, 4, 5, 6, 7, 0, 1, 2), 8'h00);
        vecs[1]  = mkv(13'h0042, 64'h40, 8'd3, 3'd2, 2'd1, pk8(8, 8, 9, 9, 0, 0, 0, 0), 8'h00);
        vecs[2]  = mkv(13'h0001, 64'h30, 8'd2, 3'd3, 2'd0, pk8(6, 6, 6, 0, 0, 0, 0, 0), 8'h00);
        vecs[3]  = mkv(13'h0002, 64'h38, 8'd3, 3'd2, 2'd2, pk8(7, 7, 6, 6, 0, 0, 0, 0), 8'h00);
        vecs[4]  = mkv(13'h1FFF, 64'h00, 8'd2, 3'd3, 2'd2, pk8(0, 0, 0, 0, 0, 0, 0, 0), 8'h07);
        vecs[5]  = mkv(13'h0003, 64'h08, 8'd1, 3'd3, 2'd3, pk8(0, 0, 0, 0, 0, 0, 0, 0), 8'h03);
        vecs[6]  = mkv(13'h0004, 64'h10, 8'd0, 3'd4, 2'd1, pk8(0, 0, 0, 0, 0, 0, 0, 0), 8'h01);
        vecs[7]  = mkv(13'h0005, 64'h1C, 8'd1, 3'd3, 2'd2, pk8(0, 0, 0, 0, 0, 0, 0, 0), 8'h03);
        vecs[8]  = mkv(13'h0006, 64'h7FF0, 8'd3, 3'd3, 2'd1, pk8(4094, 4095, 0, 1, 0, 0, 0, 0), ERR_CROSS);
        vecs[9]  = mkv(13'h1ABC, 64'h28, 8'd0, 3'd3, 2'd1, pk8(5, 0, 0, 0, 0, 0, 0, 0), 8'h00);
        vecs[10] = mkv(13'h0007, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'd1, pk8(4095, 0, 0, 0, 0, 0, 0, 0), ERR_TOP);
        vecs[11] = mkv(13'h0008, 64'h18, 8'd1, 3'd3, 2'd2, pk8(3, 2, 0, 0, 0, 0, 0, 0), 8'h00);

        #1;
        check("rst_rvalid", {63'd0, rvalid_w[0]}, 64'd0);
        check("rst_arready", {63'd0, arready_w[0]}, 64'd0);
        check("rst_rdata", rdata_w[0], 64'd0);
        check("rst_rid", {51'd0, rid_w[0]}, 64'd0);
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 12'(i); ld_data = img(16'(i));
        end
        @(negedge clk);
        ld_en = 1'b0;
        check("rst_arready_held", {63'd0, arready_w[1]}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("arready_release0", {63'd0, arready_w[0]}, 64'd1);
        check("arready_release1", {63'd0, arready_w[1]}, 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_burst(0, vecs[i], 16'hFFFF, 1);
        end

        // rready pattern 1,0,0,1 repeating
        run_burst(0, mkv(13'h0009, 64'h0, 8'd3, 3'd3, 2'd1, pk8(0, 1, 2, 3, 0, 0, 0, 0), 8'h00), 16'h9999, 1);
        run_burst(1, vecs[9], 16'hFFFF, 4);
        run_burst(1, vecs[0], 16'h5A5A, 4);

        // Reset while the third beat of an 8-beat wrap is on the bus.
        @(negedge clk);
        arid = 13'h0123; araddr = 64'h18; arlen = 8'd7; arsize = 3'd3; arburst = 2'd2;
        arvalid[0] = 1'b1;
        @(posedge clk);
        #1 arvalid[0] = 1'b0;
        rready = 1'b1;
        b = 0;
        for (int cyc = 0; cyc < 20 && b < 2; cyc++) begin
            @(negedge clk);
            if (rvalid_w[0]) b++;
        end
        @(negedge clk);
        check("midrst_beat3", rdata_w[0], img(16'd5));
        #1 reset_n = 1'b0;
        #1;
        check("midrst_rvalid", {63'd0, rvalid_w[0]}, 64'd0);
        check("midrst_rdata", rdata_w[0], 64'd0);
        check("midrst_rlast", {63'd0, rlast_w[0]}, 64'd0);
        check("midrst_rid", {51'd0, rid_w[0]}, 64'd0);
        check("midrst_arready", {63'd0, arready_w[0]}, 64'd0);
        repeat (2) @(negedge clk);
        check("midrst_quiet", {63'd0, rvalid_w[0]}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("postrst_arready", {63'd0, arready_w[0]}, 64'd1);
        check("postrst_rvalid", {63'd0, rvalid_w[0]}, 64'd0);
        run_burst(0, vecs[0], 16'hFFFF, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
